// File: rtl/io_responder_pkg.sv
// Shared constants and access decode for the memory-mapped I/O responder.
package io_responder_pkg;

    localparam logic [17:0] IoInPort  = 18'h30000;
    localparam logic [17:0] IoClkPort = 18'h30004;
    localparam logic [1:0]  IoHitBits = 2'b11;

    typedef enum logic [2:0] {
        AccNone,
        AccRdIn,
        AccRdCnt,
        AccRdSnap,
        AccRdZero,
        AccWrIn,
        AccWrClk
    } acc_e;

    // Writes to unmapped hit addresses decode to AccNone so they are ignored.
    function automatic acc_e decode_acc(input logic [17:0] addr, input logic wr);
        if (addr[17:16] != IoHitBits) return AccNone;
        if (wr) begin
            if (addr == IoInPort)  return AccWrIn;
            if (addr == IoClkPort) return AccWrClk;
            return AccNone;
        end
        if (addr == IoInPort)              return AccRdIn;
        if (addr == IoClkPort)             return AccRdCnt;
        if (addr[17:2] == IoClkPort[17:2]) return AccRdSnap;
        return AccRdZero;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU byte bus plus host rx/tx byte streams seen by the I/O responder.
interface io_responder_if;

    logic [17:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        io_rvalid;
    logic        cpu_rdy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  bus_addr, bus_wr, bus_wdata, rx_data, rx_valid, tx_ready,
        output bus_rdata, io_rvalid, cpu_rdy, rx_ready, tx_data, tx_valid
    );

    modport master (
        output bus_addr, bus_wr, bus_wdata, rx_data, rx_valid, tx_ready,
        input  bus_rdata, io_rvalid, cpu_rdy, rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/io_responder_byte_fifo.sv
// Byte FIFO with 2^AW entries; pointers carry an extra wrap bit for full/empty.
module io_responder_byte_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned Depth = 1 << AW;

    logic [7:0]  mem_q [Depth];
    logic [AW:0] wptr_q, rptr_q;
    logic        do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Storage is not reset, so mask the head while empty to present 0x00.
    assign head    = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: rx/tx byte ports, cycle counter snapshot and program stop.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    io_responder_if.slave  bus,
    output logic           prog_stop
);

    acc_e        acc;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0]  rx_head, tx_head;
    logic        rx_pop, tx_push, stall, rd_accept;
    logic [7:0]  tx_push_data, rdata_d, rdata_q;
    logic        rvalid_q, prog_stop_q;
    logic [31:0] cycle_cnt_q, cycle_cnt_d, snap_q;

    assign acc = decode_acc(bus.bus_addr, bus.bus_wr);

    always_comb begin
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = bus.bus_wdata;
        stall        = 1'b0;
        rd_accept    = 1'b0;
        rdata_d      = 8'h00;
        case (acc)
            AccRdIn: begin
                rx_pop    = ~rx_empty;
                stall     = rx_empty;
                rd_accept = ~rx_empty;
                rdata_d   = rx_head;
            end
            AccRdCnt: begin
                rd_accept = 1'b1;
                rdata_d   = cycle_cnt_q[7:0];
            end
            AccRdSnap: begin
                rd_accept = 1'b1;
                rdata_d   = snap_q[{bus.bus_addr[1:0], 3'b000} +: 8];
            end
            AccRdZero: rd_accept = 1'b1;
            AccWrIn: begin
                // A zero byte is the CPU's "nothing to send" and is dropped.
                if (bus.bus_wdata != 8'h00) begin
                    tx_push = 1'b1;
                    stall   = tx_full;
                end
            end
            AccWrClk: begin
                if (!prog_stop_q) begin
                    tx_push      = 1'b1;
                    tx_push_data = 8'h00;
                    stall        = tx_full;
                end
            end
            default: ;
        endcase
    end

    assign cycle_cnt_d = prog_stop_q ? cycle_cnt_q : cycle_cnt_q + 32'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt_q <= '0;
            snap_q      <= '0;
            prog_stop_q <= 1'b0;
            rdata_q     <= 8'h00;
            rvalid_q    <= 1'b0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            rvalid_q    <= rd_accept;
            if (rd_accept)       rdata_q <= rdata_d;
            if (acc == AccRdCnt) snap_q  <= cycle_cnt_q;
            if (acc == AccWrClk && !prog_stop_q && !tx_full) prog_stop_q <= 1'b1;
        end
    end

    io_responder_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (bus.rx_valid),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    io_responder_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (bus.tx_ready),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    // Reset must never leave the CPU stalled.
    assign bus.cpu_rdy   = rst_in | ~stall;
    assign bus.bus_rdata = rdata_q;
    assign bus.io_rvalid = rvalid_q;
    assign bus.rx_ready  = ~rx_full;
    assign bus.tx_valid  = ~tx_empty;
    assign bus.tx_data   = tx_head;
    assign prog_stop     = prog_stop_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder.
module tb_io_responder;

    localparam logic [17:0] AIn  = 18'h30000;
    localparam logic [17:0] AClk = 18'h30004;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prog_stop;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_cnt;
    logic        m_freeze = 1'b0;
    logic [31:0] exp_c;
    logic [7:0]  exp_b;

    io_responder_if bus_if ();

    io_responder #(.FIFO_AW(4)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .bus       (bus_if),
        .prog_stop (prog_stop)
    );

    always #5 clk = ~clk;

    // Reference cycle counter
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 32'd0;
        else if (!m_freeze) m_cnt <= m_cnt + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [17:0] a);
        bus_if.bus_addr  = a;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_wdata = 8'h00;
    endtask

    task automatic bus_wrt(input logic [17:0] a, input logic [7:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_wdata = d;
    endtask

    task automatic bus_idle();
        bus_if.bus_addr  = 18'h00000;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_wdata = 8'h00;
    endtask

    initial begin
        bus_idle();
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_ready = 1'b0;
        #3;
        chk("rst_rdata", bus_if.bus_rdata, 0);
        chk("rst_rvalid", bus_if.io_rvalid, 0);
        chk("rst_rx_ready", bus_if.rx_ready, 1);
        chk("rst_tx_valid", bus_if.tx_valid, 0);
        chk("rst_tx_data", bus_if.tx_data, 0);
        chk("rst_prog_stop", prog_stop, 0);
        bus_rd(AIn);
        #1 chk("rst_cpu_rdy", bus_if.cpu_rdy, 1);
        bus_idle();
        tick();
        tick();
        rst = 1'b0;

        // 1: two host bytes, two CPU reads
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h41;
        tick();
        bus_if.rx_data  = 8'h42;
        tick();
        bus_if.rx_valid = 1'b0;
        bus_rd(AIn);
        #1 chk("t1_rdy", bus_if.cpu_rdy, 1);
        tick();
        chk("t1_rdata0", bus_if.bus_rdata, 8'h41);
        chk("t1_rvalid0", bus_if.io_rvalid, 1);
        tick();
        chk("t1_rdata1", bus_if.bus_rdata, 8'h42);
        chk("t1_rvalid1", bus_if.io_rvalid, 1);
        bus_idle();
        tick();
        chk("t1_rvalid_off", bus_if.io_rvalid, 0);

        // 2: read stalls on empty rx until the host delivers
        bus_rd(AIn);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus_if.rx_valid = 1'b1;
                bus_if.rx_data  = 8'h7F;
            end
            #1 chk("t2_stall", bus_if.cpu_rdy, 0);
            chk("t2_no_rvalid", bus_if.io_rvalid, 0);
            tick();
        end
        bus_if.rx_valid = 1'b0;
        #1 chk("t2_rdy", bus_if.cpu_rdy, 1);
        tick();
        chk("t2_rdata", bus_if.bus_rdata, 8'h7F);
        chk("t2_rvalid", bus_if.io_rvalid, 1);
        bus_idle();
        tick();
        bus_rd(AIn);
        #1 chk("t2_empty_after", bus_if.cpu_rdy, 0);
        bus_idle();

        // 3: fill tx, 17th write stalls, drain in order
        for (int i = 0; i < 16; i++) begin
            bus_wrt(AIn, 8'h10 + 8'(i));
            #1 chk("t3_wr_rdy", bus_if.cpu_rdy, 1);
            tick();
        end
        bus_wrt(AIn, 8'h99);
        #1 chk("t3_full_stall", bus_if.cpu_rdy, 0);
        tick();
        chk("t3_full_stall2", bus_if.cpu_rdy, 0);
        chk("t3_head0", bus_if.tx_data, 8'h10);
        bus_if.tx_ready = 1'b1;
        #1 chk("t3_full_stall3", bus_if.cpu_rdy, 0);
        tick();
        chk("t3_unstall", bus_if.cpu_rdy, 1);
        chk("t3_head1", bus_if.tx_data, 8'h11);
        tick();
        bus_idle();
        for (int k = 2; k < 17; k++) begin
            exp_b = (k < 16) ? 8'h10 + 8'(k) : 8'h99;
            chk("t3_tx_valid", bus_if.tx_valid, 1);
            chk("t3_tx_data", bus_if.tx_data, exp_b);
            tick();
        end
        chk("t3_drained", bus_if.tx_valid, 0);
        bus_wrt(AIn, 8'h00);
        #1 chk("t3_zero_rdy", bus_if.cpu_rdy, 1);
        tick();
        bus_idle();
        #1 chk("t3_zero_no_push", bus_if.tx_valid, 0);
        bus_wrt(18'h30002, 8'h33);
        tick();
        bus_idle();
        #1 chk("t3_other_wr", bus_if.tx_valid, 0);
        bus_if.tx_ready = 1'b0;

        // Live counter read
        bus_rd(AClk);
        exp_c = m_cnt;
        tick();
        chk("cnt_live", bus_if.bus_rdata, {24'h0, exp_c[7:0]});
        bus_idle();

        // 4: snapshot bytes and wrap
        force dut.cycle_cnt_q = 32'h123456FF;
        bus_rd(AClk);
        tick();
        chk("t4_b0", bus_if.bus_rdata, 8'hFF);
        release dut.cycle_cnt_q;
        bus_rd(18'h30005);
        tick();
        chk("t4_b1", bus_if.bus_rdata, 8'h56);
        bus_rd(18'h30006);
        tick();
        chk("t4_b2", bus_if.bus_rdata, 8'h34);
        bus_rd(18'h30007);
        tick();
        chk("t4_b3", bus_if.bus_rdata, 8'h12);
        bus_rd(18'h30001);
        tick();
        chk("t4_other_rd", bus_if.bus_rdata, 8'h00);
        chk("t4_other_rvalid", bus_if.io_rvalid, 1);
        bus_idle();
        force dut.cycle_cnt_q = 32'hFFFFFFFF;
        #1 chk("t4_wrap", dut.cycle_cnt_d, 32'h0);
        release dut.cycle_cnt_q;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 5: program stop
        tick();
        tick();
        bus_wrt(AClk, 8'h55);
        #1 chk("t5_rdy", bus_if.cpu_rdy, 1);
        tick();
        m_freeze = 1'b1;
        bus_idle();
        chk("t5_prog_stop", prog_stop, 1);
        chk("t5_tx_valid", bus_if.tx_valid, 1);
        chk("t5_tx_data", bus_if.tx_data, 8'h00);
        tick();
        tick();
        tick();
        bus_rd(AClk);
        exp_c = m_cnt;
        tick();
        chk("t5_frozen", bus_if.bus_rdata, {24'h0, exp_c[7:0]});
        bus_wrt(AClk, 8'h55);
        tick();
        bus_idle();
        bus_if.tx_ready = 1'b1;
        #1 chk("t5_one_byte_v", bus_if.tx_valid, 1);
        chk("t5_one_byte_d", bus_if.tx_data, 8'h00);
        tick();
        chk("t5_no_second", bus_if.tx_valid, 0);
        bus_if.tx_ready = 1'b0;

        // 6: async reset with data in both FIFOs
        bus_if.rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.rx_data = 8'hB1 + 8'(i);
            bus_wrt(AIn, 8'hA1 + 8'(i));
            tick();
        end
        bus_if.rx_valid = 1'b0;
        bus_rd(AIn);
        tick();
        chk("t6_pre_rdata", bus_if.bus_rdata, 8'hB1);
        chk("t6_pre_tx", bus_if.tx_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rdata", bus_if.bus_rdata, 0);
        chk("t6_rvalid", bus_if.io_rvalid, 0);
        chk("t6_rx_ready", bus_if.rx_ready, 1);
        chk("t6_tx_valid", bus_if.tx_valid, 0);
        chk("t6_tx_data", bus_if.tx_data, 0);
        chk("t6_prog_stop", prog_stop, 0);
        chk("t6_cpu_rdy", bus_if.cpu_rdy, 1);
        tick();
        rst = 1'b0;
        #1 chk("t6_rx_empty", bus_if.cpu_rdy, 0);
        chk("t6_tx_empty", bus_if.tx_valid, 0);
        bus_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
